trace_feeder: RTL and testbench
===============================

# trace_feeder

Synthesizable trace source that drives the cache simulator's trace port from an on-chip trace memory. It replaces file-based stimulus for on-FPGA runs. It walks a preloaded address ROM, presents each 32-bit address with a one-cycle `trace_ready` pulse, and waits for the cache's `updated` acknowledgement before advancing. A watchdog aborts the run if the cache stops responding.

## Interface
Parameters:
- `ADDR_W`, default 32: width of trace addresses (`mem_addr`, `rom_data`).
- `IDX_W`, default 14: trace ROM index width; the ROM holds up to 2^IDX_W entries.
- `CNT_W`, default 20: width of `issued_count`; matches the cache's hit/miss counters.
- `TIMEOUT`, default 1024: maximum number of cycles to wait for `updated` before aborting.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a run. Sampled only in IDLE or DONE.
- `trace_len`, in, IDX_W+1: number of addresses to issue. Sampled on an accepted `start`.
- `rom_en`, out, 1: trace ROM read enable.
- `rom_addr`, out, IDX_W: trace ROM read index.
- `rom_data`, in, ADDR_W: ROM read data, valid exactly 1 cycle after `rom_en`.
- `trace_ready`, out, 1: one-cycle pulse; `mem_addr` is valid.
- `mem_addr`, out, ADDR_W: address presented to the cache.
- `updated`, in, 1: cache has finished processing the current address.
- `busy`, out, 1: high in every state except IDLE and DONE.
- `done`, out, 1: high while in DONE.
- `timeout_err`, out, 1: sticky abort flag; cleared by `rst` or an accepted `start`.
- `issued_count`, out, CNT_W: number of addresses acknowledged by `updated` in the current run.

## Operation
- FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT_UPD, DONE.
- IDLE/DONE with `start`=1:
  - latch `trace_len`;
  - clear `idx`, `issued_count`, `timeout_err`;
  - go to FETCH, or straight to DONE if `trace_len`==0.
- FETCH: drive `rom_en`=1 and `rom_addr`=`idx`, then go to LOAD.
- LOAD: register `rom_data` into `mem_addr`, then go to ISSUE.
- ISSUE: `trace_ready`=1 for exactly this cycle; clear the watchdog; go to WAIT_UPD.
- WAIT_UPD:
  - on `updated`=1: increment `idx` and `issued_count`; go to DONE if `idx`+1 == latched length, else go to FETCH.
  - otherwise increment the watchdog; when it reaches TIMEOUT, set `timeout_err` and go to DONE.
- `updated` is ignored in every state except WAIT_UPD, including the ISSUE cycle itself.
- `mem_addr` stays stable from the ISSUE cycle until the next LOAD. The cache may sample it at any time during WAIT_UPD.
- `start` in FETCH, LOAD, ISSUE or WAIT_UPD is ignored. `trace_len` changes mid-run have no effect.
- `issued_count` wraps modulo 2^CNT_W. A compile-time check requires IDX_W < CNT_W, so wrap cannot occur.

## Timing
- Reset values: state IDLE; `rom_en`=0, `rom_addr`=0, `trace_ready`=0, `mem_addr`=0, `busy`=0, `done`=0, `timeout_err`=0, `issued_count`=0.
- Reset asserted mid-run returns to IDLE on the same edge. No further `trace_ready` pulse is issued.
- `start` sampled at edge N:
  - FETCH during cycle N+1;
  - LOAD during N+2;
  - `trace_ready`=1 with the valid `mem_addr` during N+3.
- `updated` sampled at edge M in WAIT_UPD: the next `trace_ready` pulse is in cycle M+3.
- Per-address cost is 4 cycles plus the cache response time.
- Last acknowledgement at edge M: `done`=1 and `busy`=0 from cycle M+1.
- Timeout: if no `updated` arrives within TIMEOUT WAIT_UPD cycles, `timeout_err` and `done` rise together in the following cycle. `issued_count` holds the acknowledged total.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `trace_feeder_pkg` holds:
  - the state enum `feeder_state_t`;
  - default widths (`ADDR_W`, `IDX_W`, `CNT_W`);
  - the `TIMEOUT` default.
- One sub-module, `feeder_watchdog`:
  - inputs: `clk`, `rst`, `clear`, `enable`;
  - output: `expired`;
  - counter width is `$clog2(TIMEOUT+1)`.
- The trace ROM is external: a single-port BRAM with 1-cycle read latency.

## Test plan
- Reset, then `start` with `trace_len`=3, ROM = {0x1000, 0x2004, 0x3008}, and the cache model returning `updated` 2 cycles after `trace_ready`:
  - exactly three `trace_ready` pulses, with those addresses in order;
  - first pulse 3 cycles after `start`;
  - `issued_count`=3 and `done`=1 at the end.
- `trace_len`=0: `done`=1 on the cycle after `start`; no `trace_ready` and no `rom_en` pulse.
- `updated` held high continuously from reset:
  - it is ignored in IDLE and ISSUE;
  - each address is still issued once, at a 4-cycle spacing;
  - `issued_count` matches `trace_len`=5.
- Cache model stops acknowledging after the second address, with TIMEOUT=16: `timeout_err`=1 and `done`=1 after 16 WAIT_UPD cycles; `issued_count`=2.
- Assert `rst` during WAIT_UPD of address 2 of 4:
  - all outputs return to reset values on that edge;
  - a fresh `start` replays from ROM index 0.
- `start` pulsed during a run and `trace_len` changed mid-run: neither has any effect; the run completes with the original length.

Source files
------------

// File: rtl/trace_feeder_pkg.sv
// Shared types and default widths for the trace feeder.
package trace_feeder_pkg;

  localparam int unsigned DefaultAddrW   = 32;
  localparam int unsigned DefaultIdxW    = 14;
  localparam int unsigned DefaultCntW    = 20;
  localparam int unsigned DefaultTimeout = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StIssue,
    StWaitUpd,
    StDone
  } feeder_state_t;

endpackage

// File: rtl/feeder_watchdog.sv
// Cycle counter that flags the cycle in which the TIMEOUT-th consecutive enabled cycle occurs.
module feeder_watchdog
  import trace_feeder_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is seen during the last allowed cycle so the owner can leave on that edge.
  assign expired = enable && !clear && ((count_q + CntW'(1)) == CntW'(TIMEOUT));

endmodule

// File: rtl/trace_feeder.sv
// Walks an external trace ROM, presenting each address to the cache and waiting for its ack.
module trace_feeder
  import trace_feeder_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned IDX_W   = DefaultIdxW,
  parameter int unsigned CNT_W   = DefaultCntW,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W:0]    trace_len,
  output logic              rom_en,
  output logic [IDX_W-1:0]  rom_addr,
  input  logic [ADDR_W-1:0] rom_data,
  output logic              trace_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              updated,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  issued_count
);

  if (IDX_W >= CNT_W) begin : g_width_check
    $error("IDX_W must be smaller than CNT_W");
  end

  feeder_state_t     state_q, state_d;
  logic [IDX_W:0]    len_q, len_d;
  logic [IDX_W:0]    idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic accept, ack, last, wd_clear, wd_enable, wd_expired;

  assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
  assign ack       = (state_q == StWaitUpd) && updated;
  assign last      = ((idx_q + (IDX_W + 1)'(1)) == len_q);
  assign wd_clear  = (state_q == StIssue);
  assign wd_enable = (state_q == StWaitUpd) && !updated;

  feeder_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = (trace_len == '0) ? StDone : StFetch;
      end
      StFetch:   state_d = StLoad;
      StLoad:    state_d = StIssue;
      StIssue:   state_d = StWaitUpd;
      StWaitUpd: begin
        if (updated) begin
          state_d = last ? StDone : StFetch;
        end else if (wd_expired) begin
          state_d = StDone;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    if (accept) begin
      len_d = trace_len;
      idx_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end
    if (state_q == StLoad) mem_addr_d = rom_data;
    if (ack) begin
      idx_d = idx_q + (IDX_W + 1)'(1);
      cnt_d = cnt_q + CNT_W'(1);
    end else if (wd_expired) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      len_q      <= len_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    rom_en       = (state_q == StFetch);
    rom_addr     = idx_q[IDX_W-1:0];
    trace_ready  = (state_q == StIssue);
    mem_addr     = mem_addr_q;
    busy         = (state_q != StIdle) && (state_q != StDone);
    done         = (state_q == StDone);
    timeout_err  = err_q;
    issued_count = cnt_q;
  end

endmodule

// File: tb/tb_trace_feeder.sv
// Randomized bench for trace_feeder: ROM and cache responders plus a timeline reference model.
module tb_trace_feeder;

  localparam int unsigned AddrW = 32;
  localparam int unsigned IdxW  = 6;
  localparam int unsigned CntW  = 20;
  localparam int unsigned Tmo   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [IdxW:0]     trace_len = '0;
  logic              rom_en;
  logic [IdxW-1:0]   rom_addr;
  logic [AddrW-1:0]  rom_data = '0;
  logic              trace_ready;
  logic [AddrW-1:0]  mem_addr;
  logic              updated = 1'b0;
  logic              busy, done, timeout_err;
  logic [CntW-1:0]   issued_count;

  logic [AddrW-1:0]  rom [1 << IdxW];
  int                n_vec = 0;
  int                n_err = 0;
  int                edge_cnt = 0;
  int                pulse_t[$];
  logic [AddrW-1:0]  pulse_a[$];
  int                rom_en_cnt = 0;
  int                lat_cfg = 2;
  int                acks_left = 0;
  int                upd_wait = 0;
  bit                upd_always = 1'b0;

  trace_feeder #(
    .ADDR_W (AddrW),
    .IDX_W  (IdxW),
    .CNT_W  (CntW),
    .TIMEOUT(Tmo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .trace_len   (trace_len),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .trace_ready (trace_ready),
    .mem_addr    (mem_addr),
    .updated     (updated),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Single-port BRAM with one cycle of read latency.
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // Cycle numbering: the cycle following edge k is cycle k+1.
  always @(negedge clk) begin
    if (trace_ready) begin
      pulse_t.push_back(edge_cnt + 1);
      pulse_a.push_back(mem_addr);
    end
    if (rom_en) rom_en_cnt++;
  end

  // Cache responder: acks lat_cfg cycles after a pulse, until acks_left runs out.
  always @(negedge clk) begin
    if (upd_always) begin
      updated = 1'b1;
    end else begin
      updated = 1'b0;
      if (upd_wait > 0) begin
        upd_wait--;
        if (upd_wait == 0) updated = 1'b1;
      end
      if (trace_ready && acks_left > 0) begin
        upd_wait = lat_cfg;
        acks_left--;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".rom_en"}, rom_en, 0);
    check_eq({tag, ".rom_addr"}, rom_addr, 0);
    check_eq({tag, ".trace_ready"}, trace_ready, 0);
    check_eq({tag, ".mem_addr"}, mem_addr, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".done"}, done, 0);
    check_eq({tag, ".timeout_err"}, timeout_err, 0);
    check_eq({tag, ".issued_count"}, issued_count, 0);
  endtask

  task automatic run_trace(input string tag, input int len, input int lat, input int acks,
                           input bit always_hi, input bit disturb);
    int               s_cyc, t, done_exp, done_got, n_cnt;
    bit               tmo;
    int               exp_t[$];
    logic [AddrW-1:0] exp_a[$];
    pulse_t.delete();
    pulse_a.delete();
    rom_en_cnt = 0;
    lat_cfg    = lat;
    acks_left  = acks;
    upd_wait   = 0;
    upd_always = always_hi;
    start      = 1'b1;
    trace_len  = (IdxW + 1)'(len);
    s_cyc      = edge_cnt + 1;
    // Reference timeline: pulse at S+3; ack sampled at edge M gives next pulse at M+3.
    t        = s_cyc + 3;
    done_exp = s_cyc + 1;
    tmo      = 1'b0;
    n_cnt    = 0;
    for (int k = 0; k < len; k++) begin
      exp_t.push_back(t);
      exp_a.push_back(rom[k]);
      if (k < acks) begin
        n_cnt++;
        done_exp = t + lat + 1;
        t        = t + lat + 3;
      end else begin
        tmo      = 1'b1;
        done_exp = t + Tmo + 1;
        break;
      end
    end
    @(negedge clk);
    start    = 1'b0;
    done_got = -1;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        done_got = edge_cnt + 1;
        break;
      end
      if (disturb) begin
        start     = 1'($urandom);
        trace_len = (IdxW + 1)'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq($sformatf("%s.done_cycle", tag), done_got, done_exp);
    repeat (3) @(negedge clk);
    check_eq($sformatf("%s.pulse_count", tag), pulse_t.size(), exp_t.size());
    for (int k = 0; k < exp_t.size(); k++) begin
      if (k < pulse_t.size()) begin
        check_eq($sformatf("%s.pulse%0d_cycle", tag, k), pulse_t[k], exp_t[k]);
        check_eq($sformatf("%s.pulse%0d_addr", tag, k), pulse_a[k], exp_a[k]);
      end
    end
    check_eq($sformatf("%s.rom_en_count", tag), rom_en_cnt, exp_t.size());
    check_eq($sformatf("%s.issued_count", tag), issued_count, n_cnt);
    check_eq($sformatf("%s.timeout_err", tag), timeout_err, tmo);
    check_eq($sformatf("%s.done_hold", tag), done, 1);
    check_eq($sformatf("%s.busy", tag), busy, 0);
    upd_always = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    for (int i = 0; i < (1 << IdxW); i++) rom[i] = $urandom;
    rom[0] = 32'h1000;
    rom[1] = 32'h2004;
    rom[2] = 32'h3008;

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    run_trace("basic", 3, 2, 3, 1'b0, 1'b0);
    run_trace("zero_len", 0, 2, 0, 1'b0, 1'b0);

    // updated held high from reset onwards: must not move the FSM out of IDLE.
    rst        = 1'b1;
    upd_always = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("upd_hi.idle_busy", busy, 0);
    check_eq("upd_hi.idle_done", done, 0);
    run_trace("upd_hi", 5, 1, 5, 1'b1, 1'b0);

    run_trace("timeout", 4, 2, 2, 1'b0, 1'b0);

    // Reset during WAIT_UPD of the second of four addresses.
    pulse_t.delete();
    pulse_a.delete();
    lat_cfg   = 2;
    acks_left = 1;
    upd_wait  = 0;
    start     = 1'b1;
    trace_len = (IdxW + 1)'(4);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && pulse_t.size() < 2; k++) @(negedge clk);
    @(negedge clk);
    check_eq("midrst.reached_second", pulse_t.size(), 2);
    check_eq("midrst.busy_before", busy, 1);
    #1 rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    pulse_t.delete();
    pulse_a.delete();
    repeat (5) @(negedge clk);
    check_eq("midrst.no_pulse_after", pulse_t.size(), 0);
    run_trace("replay", 4, 3, 4, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int len, lat, acks;
      len  = $urandom_range(1, 12);
      lat  = $urandom_range(1, 5);
      acks = (i % 3 == 2) ? $urandom_range(0, len - 1) : len;
      run_trace($sformatf("rnd%0d", i), len, lat, acks, 1'b0, i[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
